apb_multi_slave_decoder: RTL and testbench

//  Parametrised N-slave APB address decoder and select sequencer for the AHB-to-APB bridge.

---
 rtl/apb_dec_pkg.sv | 33 +++
 rtl/apb_dec_match.sv | 43 ++++
 rtl/apb_multi_slave_decoder.sv | 161 ++++++++++++++++
 tb/tb_apb_multi_slave_decoder.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/apb_dec_pkg.sv
// Shared types and helpers for the multi-slave APB address decoder.
// Holds the sequencer state encoding, default map constants and priority helpers.
package apb_dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } dec_state_e;

   localparam int MAX_SLV     = 16;
   localparam int DEF_NUM_SLV = 4;
   localparam int DEF_AW      = 32;
   localparam int DEF_DW      = 32;
   localparam int DEF_TIMEOUT = 16;
   localparam logic [31:0] DEF_PAGE_MASK = 32'hFFFF_F000;

   // Isolates the lowest set bit, so the lowest-numbered slave wins overlaps.
   function automatic logic [MAX_SLV-1:0] onehot_prio(input logic [MAX_SLV-1:0] vec);
      return vec & (~vec + MAX_SLV'(1));
   endfunction

   function automatic int onehot_idx(input logic [MAX_SLV-1:0] oh);
      int idx;
      idx = 0;
      for (int i = 0; i < MAX_SLV; i++) begin
         if (oh[i]) idx = i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/apb_dec_match.sv
// Combinational base/mask address match for every slave.
// Produces the prioritised one-hot select, an any-hit flag and the winning index.
module apb_dec_match
   import apb_dec_pkg::*;
#(
   parameter int                      NUM_SLV  = DEF_NUM_SLV,
   parameter int                      AW       = DEF_AW,
   parameter int                      IW       = 2,
   parameter logic [NUM_SLV*AW-1:0]   SLV_BASE = '0,
   parameter logic [NUM_SLV*AW-1:0]   SLV_MASK = '0
) (
   input  logic [AW-1:0]      haddr_i,
   output logic [NUM_SLV-1:0] onehot_o,
   output logic               hit_any_o,
   output logic [IW-1:0]      first_idx_o
);

   logic [NUM_SLV-1:0] raw_hit;
   logic [NUM_SLV-1:0] hit_vec;
   logic [MAX_SLV-1:0] hit_pad;
   logic               addr_nz;

   generate
      for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_cmp
         assign raw_hit[gi] = ((haddr_i & SLV_MASK[gi*AW +: AW]) ==
                               (SLV_BASE[gi*AW +: AW] & SLV_MASK[gi*AW +: AW]));
      end
   endgenerate

   // A null address is treated as a bus error even if some slot would match it.
   assign addr_nz = |haddr_i;
   assign hit_vec = raw_hit & {NUM_SLV{addr_nz}};

   always_comb begin
      hit_pad                = '0;
      hit_pad[NUM_SLV-1:0]   = hit_vec;
   end

   assign hit_any_o   = |hit_vec;
   assign first_idx_o = IW'(onehot_idx(onehot_prio(hit_pad)));
   assign onehot_o    = hit_any_o ? (NUM_SLV'(1) << first_idx_o) : '0;

endmodule

// File: rtl/apb_multi_slave_decoder.sv
// APB select sequencer: decodes HADDR to one slave, walks SETUP/ACCESS, and
// returns the selected slave's response or an error on decode miss / timeout.
module apb_multi_slave_decoder
   import apb_dec_pkg::*;
#(
   parameter int                      NUM_SLV  = DEF_NUM_SLV,
   parameter int                      AW       = DEF_AW,
   parameter int                      DW       = DEF_DW,
   parameter logic [NUM_SLV*AW-1:0]   SLV_BASE = '0,
   parameter logic [NUM_SLV*AW-1:0]   SLV_MASK = '0,
   parameter int                      TIMEOUT  = DEF_TIMEOUT,
   localparam int                     IW       = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [AW-1:0]         HADDR,
   input  logic                  start,
   output logic [NUM_SLV-1:0]    PSEL,
   output logic                  PENABLE,
   input  logic [NUM_SLV-1:0]    PREADY_s,
   input  logic [NUM_SLV-1:0]    PSLVERR_s,
   input  logic [NUM_SLV*DW-1:0] PRDATA_s,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [DW-1:0]         rdata,
   output logic [IW-1:0]         sel_idx
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   dec_state_e          state_q,   state_d;
   logic [NUM_SLV-1:0]  psel_q,    psel_d;
   logic                penable_q, penable_d;
   logic                done_q,    done_d;
   logic                err_q,     err_d;
   logic [DW-1:0]       rdata_q,   rdata_d;
   logic [IW-1:0]       sel_idx_q, sel_idx_d;
   logic [CW-1:0]       cnt_q,     cnt_d;

   logic [NUM_SLV-1:0]  dec_onehot;
   logic                dec_hit;
   logic [IW-1:0]       dec_idx;
   logic                pready_sel;
   logic                pslverr_sel;
   logic [DW-1:0]       prdata_sel;
   logic                timed_out;

   apb_dec_match #(
      .NUM_SLV  (NUM_SLV),
      .AW       (AW),
      .IW       (IW),
      .SLV_BASE (SLV_BASE),
      .SLV_MASK (SLV_MASK)
   ) u_match (
      .haddr_i     (HADDR),
      .onehot_o    (dec_onehot),
      .hit_any_o   (dec_hit),
      .first_idx_o (dec_idx)
   );

   // Response path is steered by the latched index; other slaves' PREADY is ignored.
   assign pready_sel  = PREADY_s[sel_idx_q];
   assign pslverr_sel = PSLVERR_s[sel_idx_q];
   assign prdata_sel  = PRDATA_s[sel_idx_q*DW +: DW];
   assign timed_out   = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         psel_q    <= '0;
         penable_q <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         sel_idx_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         done_q    <= done_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
         sel_idx_q <= sel_idx_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      done_d    = 1'b0;
      err_d     = err_q;
      rdata_d   = rdata_q;
      sel_idx_d = sel_idx_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (dec_hit) begin
                  state_d   = SETUP;
                  sel_idx_d = dec_idx;
                  psel_d    = dec_onehot;
                  penable_d = 1'b0;
               end else begin
                  state_d   = RESP;
                  psel_d    = '0;
                  done_d    = 1'b1;
                  err_d     = 1'b1;
                  rdata_d   = '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
            cnt_d     = '0;
         end
         ACCESS: begin
            // PREADY is checked first so a ready on the last allowed cycle still completes normally.
            if (pready_sel) begin
               state_d   = RESP;
               psel_d    = '0;
               penable_d = 1'b0;
               done_d    = 1'b1;
               err_d     = pslverr_sel;
               rdata_d   = prdata_sel;
            end else if (timed_out) begin
               state_d   = RESP;
               psel_d    = '0;
               penable_d = 1'b0;
               done_d    = 1'b1;
               err_d     = 1'b1;
               rdata_d   = '0;
            end else if (cnt_q != '1) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d   = IDLE;
            psel_d    = '0;
            penable_d = 1'b0;
         end
      endcase
   end

   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign busy    = (state_q != IDLE);
   assign done    = done_q;
   assign err     = err_q;
   assign rdata   = rdata_q;
   assign sel_idx = sel_idx_q;

endmodule

// File: tb/tb_apb_multi_slave_decoder.sv
// Directed bench for the APB decoder: normal, miss, wait states, timeout,
// overlapping maps, ignored start and asynchronous reset mid-transfer.
module tb_apb_multi_slave_decoder;

   localparam int NS = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   localparam logic [NS*AW-1:0] MAP_BASE = {32'h4002_0000, 32'h4001_0000, 32'h4000_1000, 32'h4000_0000};
   localparam logic [NS*AW-1:0] MAP_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000};
   // Slot 0 widened to a 64 KB window so it overlaps slot 1.
   localparam logic [NS*AW-1:0] OVL_MASK = {32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000};

   logic               HCLK = 1'b0;
   logic               HRESETn;
   logic [AW-1:0]      HADDR;
   logic               start;
   logic [NS-1:0]      PREADY_s;
   logic [NS-1:0]      PSLVERR_s;
   logic [NS*DW-1:0]   PRDATA_s;
   logic [NS-1:0]      PSEL;
   logic               PENABLE, busy, done, err;
   logic [DW-1:0]      rdata;
   logic [1:0]         sel_idx;

   logic [NS-1:0]      ov_pready;
   logic [NS-1:0]      ov_psel;
   logic               ov_penable, ov_busy, ov_done, ov_err;
   logic [DW-1:0]      ov_rdata;
   logic [1:0]         ov_sel_idx;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 HCLK = ~HCLK;

   apb_multi_slave_decoder #(
      .NUM_SLV(NS), .AW(AW), .DW(DW),
      .SLV_BASE(MAP_BASE), .SLV_MASK(MAP_MASK), .TIMEOUT(16)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .start(start),
      .PSEL(PSEL), .PENABLE(PENABLE),
      .PREADY_s(PREADY_s), .PSLVERR_s(PSLVERR_s), .PRDATA_s(PRDATA_s),
      .busy(busy), .done(done), .err(err), .rdata(rdata), .sel_idx(sel_idx)
   );

   apb_multi_slave_decoder #(
      .NUM_SLV(NS), .AW(AW), .DW(DW),
      .SLV_BASE(MAP_BASE), .SLV_MASK(OVL_MASK), .TIMEOUT(16)
   ) dut_ovl (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .start(start),
      .PSEL(ov_psel), .PENABLE(ov_penable),
      .PREADY_s(ov_pready), .PSLVERR_s(PSLVERR_s), .PRDATA_s(PRDATA_s),
      .busy(ov_busy), .done(ov_done), .err(ov_err), .rdata(ov_rdata), .sel_idx(ov_sel_idx)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] check %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   initial begin
      HRESETn   = 1'b0;
      HADDR     = '0;
      start     = 1'b0;
      PREADY_s  = '0;
      PSLVERR_s = '0;
      ov_pready = '1;
      PRDATA_s  = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_psel",    PSEL,    4'b0000);
      chk("rst_penable", PENABLE, 1'b0);
      chk("rst_busy",    busy,    1'b0);
      chk("rst_done",    done,    1'b0);
      chk("rst_err",     err,     1'b0);
      chk("rst_rdata",   rdata,   32'h0);
      chk("rst_sel_idx", sel_idx, 2'd0);
      #3 HRESETn = 1'b1;
      step();

      // 1: zero-wait transfer to slave 1
      HADDR = 32'h4000_1004; start = 1'b1; PREADY_s = 4'b0010;
      step(); start = 1'b0;
      chk("t1_setup_psel",    PSEL,    4'b0010);
      chk("t1_setup_penable", PENABLE, 1'b0);
      chk("t1_setup_idx",     sel_idx, 2'd1);
      chk("t1_setup_done",    done,    1'b0);
      step();
      chk("t1_acc_psel",      PSEL,    4'b0010);
      chk("t1_acc_penable",   PENABLE, 1'b1);
      step();
      chk("t1_done",          done,    1'b1);
      chk("t1_err",           err,     1'b0);
      chk("t1_rdata",         rdata,   32'hBBBB_0001);
      chk("t1_resp_psel",     PSEL,    4'b0000);
      chk("t1_resp_penable",  PENABLE, 1'b0);
      PREADY_s = 4'b0000;
      step();
      chk("t1_done_pulse",    done,    1'b0);
      chk("t1_idle_busy",     busy,    1'b0);

      // 2: decode misses, unmapped then null address
      HADDR = 32'h5000_0000; start = 1'b1;
      step(); start = 1'b0;
      chk("t2a_psel", PSEL, 4'b0000);
      chk("t2a_done", done, 1'b1);
      chk("t2a_err",  err,  1'b1);
      step();
      chk("t2a_done_pulse", done, 1'b0);
      HADDR = 32'h0000_0000; start = 1'b1;
      step(); start = 1'b0;
      chk("t2b_psel", PSEL, 4'b0000);
      chk("t2b_done", done, 1'b1);
      chk("t2b_err",  err,  1'b1);
      step();

      // 3: slave 2 waits 5 cycles, other slaves' PREADY ignored, then errors
      HADDR = 32'h4001_0000; start = 1'b1;
      step(); start = 1'b0;
      chk("t3_setup_psel", PSEL, 4'b0100);
      step();
      PREADY_s = 4'b1011;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t3_wait%0d_psel", i), PSEL, 4'b0100);
         chk($sformatf("t3_wait%0d_done", i), done, 1'b0);
         step();
      end
      PREADY_s = 4'b0100; PSLVERR_s = 4'b0100;
      chk("t3_acc6_psel", PSEL,    4'b0100);
      chk("t3_acc6_pen",  PENABLE, 1'b1);
      step();
      chk("t3_done",  done,  1'b1);
      chk("t3_err",   err,   1'b1);
      chk("t3_rdata", rdata, 32'hCCCC_0002);
      chk("t3_psel",  PSEL,  4'b0000);
      PREADY_s = 4'b0000; PSLVERR_s = 4'b0000;
      step();

      // 4: slave 3 never ready, timeout after 16 ACCESS cycles
      HADDR = 32'h4002_0000; start = 1'b1;
      step(); start = 1'b0;
      chk("t4_setup_psel", PSEL, 4'b1000);
      step();
      for (int i = 0; i < 15; i++) begin
         chk($sformatf("t4_acc%0d_done", i + 1), done, 1'b0);
         step();
      end
      chk("t4_acc16_psel", PSEL,    4'b1000);
      chk("t4_acc16_pen",  PENABLE, 1'b1);
      step();
      chk("t4_done",    done,    1'b1);
      chk("t4_err",     err,     1'b1);
      chk("t4_rdata",   rdata,   32'h0);
      chk("t4_psel",    PSEL,    4'b0000);
      chk("t4_penable", PENABLE, 1'b0);
      step();

      // 5: overlapping map picks lowest index; start during ACCESS ignored
      HADDR = 32'h4000_1004; start = 1'b1;
      step(); start = 1'b0;
      chk("t5_ovl_psel", ov_psel,    4'b0001);
      chk("t5_ovl_idx",  ov_sel_idx, 2'd0);
      chk("t5_main_psel", PSEL,      4'b0010);
      step();
      chk("t5_ovl_pen",  ov_penable, 1'b1);
      HADDR = 32'h4002_0000; start = 1'b1;
      step(); start = 1'b0;
      chk("t5_ign_psel", PSEL,    4'b0010);
      chk("t5_ign_idx",  sel_idx, 2'd1);
      chk("t5_ign_done", done,    1'b0);
      PREADY_s = 4'b0010;
      step();
      chk("t5_done",  done,  1'b1);
      chk("t5_rdata", rdata, 32'hBBBB_0001);
      PREADY_s = 4'b0000;
      step();
      chk("t5_idle_busy", busy, 1'b0);
      step();
      chk("t5_no_retrigger", busy, 1'b0);

      // 6: asynchronous reset during ACCESS
      HADDR = 32'h4000_0000; start = 1'b1;
      step(); start = 1'b0;
      step();
      chk("t6_acc_psel", PSEL,    4'b0001);
      chk("t6_acc_pen",  PENABLE, 1'b1);
      #2 HRESETn = 1'b0;
      #1;
      chk("t6_rst_psel", PSEL,    4'b0000);
      chk("t6_rst_pen",  PENABLE, 1'b0);
      chk("t6_rst_busy", busy,    1'b0);
      chk("t6_rst_done", done,    1'b0);
      PREADY_s = 4'b0001;
      step();
      chk("t6_hold_done", done, 1'b0);
      #2 HRESETn = 1'b1;
      step();
      chk("t6_post_done", done, 1'b0);
      chk("t6_post_busy", busy, 1'b0);
      PREADY_s = 4'b0000;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
